// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand request and write-back packet between issue logic and muldiv_unit
interface muldiv_unit_if #(
  parameter int Address_Width = 5,
  parameter int Data_Width = 32
);
  logic start;
  logic [1:0] op;
  logic [Data_Width-1:0] rs1_data;
  logic [Data_Width-1:0] rs2_data;
  logic [Address_Width-1:0] rd_in;
  logic busy;
  logic done;
  logic we;
  logic [Data_Width-1:0] result;
  logic [Address_Width-1:0] rd_out;
  modport master (
    output start, op, rs1_data, rs2_data, rd_in,
    input busy, done, we, result, rd_out
  );
  modport slave (
    input start, op, rs1_data, rs2_data, rd_in,
    output busy, done, we, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned shift-add multiplier / restoring divider sharing one counter and datapath
module muldiv_unit #(
  parameter int Address_Width = 5,
  parameter int Data_Width = 32
) (
  input logic clk,
  input logic rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(Data_Width);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_state_nx;
  logic [1:0] r_op;
  logic [Data_Width:0] r_hi;
  logic [Data_Width-1:0] r_lo, r_b, r_result;
  logic [Address_Width-1:0] r_rd, r_rd_out;
  logic [CW-1:0] r_cnt;
  logic w_accept, w_div0, w_last;
  logic [Data_Width:0] w_sum, w_shift, w_hi_nx;
  logic [Data_Width+1:0] w_diff;
  logic [Data_Width-1:0] w_lo_nx;
  assign w_accept = r_state == IDLE && bus.start;
  assign w_div0 = bus.op[1] && bus.rs2_data == '0;
  assign w_last = r_cnt == CW'(Data_Width - 1);
  // One iteration: r_hi is the running high product / partial remainder, r_lo the multiplier / dividend-quotient
  always_comb begin
    w_sum = r_hi + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi[Data_Width-1:0], r_lo[Data_Width-1]};
    w_diff = {1'b0, w_shift} - {2'b0, r_b};
    w_hi_nx = r_op[1] ? (w_diff[Data_Width+1] ? w_shift : w_diff[Data_Width:0]) : {1'b0, w_sum[Data_Width:1]};
    w_lo_nx = r_op[1] ? {r_lo[Data_Width-2:0], ~w_diff[Data_Width+1]} : {w_sum[0], r_lo[Data_Width-1:1]};
  end
  // Next state: divide by zero skips the iteration phase entirely
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = r_state == IDLE ? (bus.start ? (w_div0 ? DONE : RUN) : IDLE) :
                 r_state == RUN ? (w_last ? DONE : RUN) : IDLE;
  end
  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_state_nx;
  end
  // Operand latch, iteration datapath and write-back packet
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_b <= '0;
      r_cnt <= '0;
      r_rd <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else if (w_accept) begin
      r_op <= bus.op;
      r_hi <= '0;
      r_lo <= bus.op[1] ? bus.rs1_data : bus.rs2_data;
      r_b <= bus.op[1] ? bus.rs2_data : bus.rs1_data;
      r_cnt <= '0;
      r_rd <= bus.rd_in;
      if (w_div0) begin
        r_result <= bus.op[0] ? bus.rs1_data : '1;
        r_rd_out <= bus.rd_in;
      end
    end else if (r_state == RUN) begin
      r_hi <= w_hi_nx;
      r_lo <= w_lo_nx;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= r_op[0] ? w_hi_nx[Data_Width-1:0] : w_lo_nx;
        r_rd_out <= r_rd;
      end
    end
  end
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_state == DONE;
  assign bus.we = r_state == DONE;
  assign bus.result = r_result;
  assign bus.rd_out = r_rd_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  muldiv_unit_if m ();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(m));
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    logic [31:0] exp;
    int n;
    exp = model(op, a, b);
    m.op = op;
    m.rs1_data = a;
    m.rs2_data = b;
    m.rd_in = rd;
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    m.op = 2'($urandom);
    m.rs1_data = $urandom;
    m.rs2_data = $urandom;
    m.rd_in = 5'($urandom);
    check({tag, ".busy"}, m.busy, 1);
    n = 0;
    while (!m.done && n < 50) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, n, (op[1] && b == 0) ? 0 : 32);
    check({tag, ".we"}, m.we, 1);
    check({tag, ".result"}, m.result, exp);
    check({tag, ".rd_out"}, m.rd_out, rd);
    tick();
    check({tag, ".busy_after"}, m.busy, 0);
    check({tag, ".done_after"}, m.done, 0);
    check({tag, ".result_hold"}, m.result, exp);
  endtask

  initial begin
    logic [31:0] got, exp, a, b;
    logic [4:0] got_rd;
    logic [1:0] op;
    int ndone, nlat;
    m.start = 1'b0;
    m.op = '0;
    m.rs1_data = '0;
    m.rs2_data = '0;
    m.rd_in = '0;
    rst = 1'b0;
    tick();
    tick();
    check("reset.busy", m.busy, 0);
    check("reset.done", m.done, 0);
    check("reset.we", m.we, 0);
    check("reset.result", m.result, 0);
    check("reset.rd_out", m.rd_out, 0);
    rst = 1'b1;
    tick();
    run_op(2'd0, 32'd7, 32'd6, 5'd5, "mul_7x6");
    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 5'd1, "mul_max_x2");
    run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 5'd2, "mulhu_max_x2");
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhu_max_sq");
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, "mul_max_sq");
    run_op(2'd2, 32'd100, 32'd7, 5'd6, "divu_100_7");
    run_op(2'd3, 32'd100, 32'd7, 5'd7, "remu_100_7");
    run_op(2'd2, 32'd5, 32'd9, 5'd8, "divu_5_9");
    run_op(2'd3, 32'd5, 32'd9, 5'd9, "remu_5_9");
    run_op(2'd2, 32'hFFFF_FFFF, 32'd1, 5'd10, "divu_max_1");
    run_op(2'd3, 32'hFFFF_FFFF, 32'd1, 5'd11, "remu_max_1");
    run_op(2'd2, 32'd123, 32'd0, 5'd12, "divu_by_zero");
    run_op(2'd3, 32'd123, 32'd0, 5'd0, "remu_by_zero");
    exp = model(2'd0, 32'd1234, 32'd5678);
    m.op = 2'd0;
    m.rs1_data = 32'd1234;
    m.rs2_data = 32'd5678;
    m.rd_in = 5'd9;
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    ndone = 0;
    nlat = -1;
    got = '0;
    got_rd = '0;
    for (int n = 0; n < 40; n++) begin
      if (m.done) begin
        ndone++;
        nlat = n;
        got = m.result;
        got_rd = m.rd_out;
      end
      if (n == 3 || n == 20) begin
        m.start = 1'b1;
        m.op = 2'd2;
        m.rs1_data = $urandom;
        m.rs2_data = 32'd0;
        m.rd_in = 5'd17;
      end else m.start = 1'b0;
      tick();
    end
    m.start = 1'b0;
    check("busy_start.done_count", ndone, 1);
    check("busy_start.latency", nlat, 32);
    check("busy_start.result", got, exp);
    check("busy_start.rd_out", got_rd, 9);
    run_op(2'd2, 32'd100, 32'd0, 5'd3, "after_busy_start");
    run_op(2'd0, 32'd9, 32'd9, 5'd4, "back_to_back");
    m.op = 2'd2;
    m.rs1_data = 32'd1000;
    m.rs2_data = 32'd3;
    m.rd_in = 5'd21;
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midreset.busy", m.busy, 0);
    check("midreset.done", m.done, 0);
    check("midreset.result", m.result, 0);
    check("midreset.rd_out", m.rd_out, 0);
    ndone = 0;
    repeat (40) begin
      if (m.done) ndone++;
      tick();
    end
    check("midreset.no_done", ndone, 0);
    run_op(2'd2, 32'd1000, 32'd3, 5'd21, "after_reset");
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 6) == 0) ? 32'd0 :
          ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(op, a, b, 5'($urandom), $sformatf("rand%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative unsigned multiply/divide execution unit, directly downstream of the register file read ports.
- Consumes rs1/rs2 operand data plus the destination register address.
- Produces a write-back packet (data, rd, write enable) for the register file write port (din/rd/en).
- Multi-cycle with a start/busy/done handshake; shares one counter and datapath between the shift-add multiplier and the restoring divider.

Parameters:
- Address_Width, 5, register address width (rd_in/rd_out).
- Data_Width, 32, operand/result width; iteration count equals Data_Width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 at a rising edge resets).
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
- rs1_data  input  Data_Width  operand A (multiplicand/dividend), from regfile rd1.
- rs2_data  input  Data_Width  operand B (multiplier/divisor), from regfile rd2.
- rd_in  input  Address_Width  destination register, captured with start.
- busy  output  1  high while an operation is accepted and not yet done.
- done  output  1  one-cycle pulse; result valid.
- we  output  1  regfile write enable; equals done.
- result  output  Data_Width  write-back data to regfile din.
- rd_out  output  Address_Width  write-back address to regfile rd.

Behaviour:
- Reset (rst=0 at edge): state IDLE; busy=0, done=0, we=0, result=0, rd_out=0; counter and internal registers cleared. Reset mid-operation abandons the op, and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at edge k, latch op, rs1_data, rs2_data, rd_in.
  - Divide op with rs2_data==0: go directly to DONE at edge k.
  - Otherwise go to RUN with count=0.
  - busy=1 from the cycle after edge k until DONE is left.
- RUN: one iteration per edge; count increments.
  - On the edge where count reaches Data_Width-1, the last iteration completes and state goes to DONE.
  - Normal latency: start sampled at edge k, so done is high in the cycle following edge k+Data_Width (32 cycles for the default).
- DONE: done=1, we=1 for exactly one cycle, busy=1. Next edge returns to IDLE with busy=0, done=0.
  - Back-to-back: start may be sampled in the IDLE cycle immediately after DONE.
- start while busy (RUN or DONE) is ignored; operands are not re-latched.
- Operand inputs may change freely after the start edge; only latched copies are used.
- result and rd_out are loaded when entering DONE and hold their value until the next DONE or reset.
- Multiply: unsigned 2*Data_Width product via shift-add. MUL returns bits [Data_Width-1:0]; MULHU returns bits [2*Data_Width-1:Data_Width].
- Divide: unsigned restoring division, one quotient bit per iteration. Remainder register is Data_Width+1 bits to hold the trial subtract. DIVU returns quotient; REMU returns remainder.
- Divide by zero (latency 1 cycle): DIVU result = all ones; REMU result = dividend. No exception.
- rd_out=0 is still presented with we=1; suppressing that write is the register file's responsibility.
- No signed ops, no overflow flag; all arithmetic is modulo 2^Data_Width on the returned word.

Test Plan:
- Reset then MUL: rs1=7, rs2=6, rd_in=5, start at edge k -> busy=1 next cycle; done=we=1 exactly in the cycle after edge k+32 with result=42, rd_out=5; busy=0 after.
- MUL/MULHU: rs1=0xFFFFFFFF, rs2=2 -> MUL result=0xFFFFFFFE; MULHU result=0x00000001. Also rs1=rs2=0xFFFFFFFF -> MULHU=0xFFFFFFFE, MUL=0x00000001.
- DIVU/REMU: rs1=100, rs2=7 -> 14 and 2. rs1=5, rs2=9 -> 0 and 5. rs1=0xFFFFFFFF, rs2=1 -> 0xFFFFFFFF and 0.
- Divide by zero: DIVU rs1=123, rs2=0 -> done in cycle after start edge, result=0xFFFFFFFF. REMU -> result=123.
- start pulsed again at cycles 3 and 20 of a running MUL with different operands -> ignored; single done with the original result. A new start in the cycle after done -> accepted.
- rst=0 at cycle 10 of a DIVU -> next cycle busy=0, done=0, result=0, rd_out=0; no done pulse for 40 cycles; a subsequent op completes correctly.
